// File: rtl/life_pkg.sv
// Shared types and default timing constants for the Game-of-Life
// generation controller.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PAUSE,
        RUN
    } pacer_state_t;

    typedef logic [1:0] speed_t;

    localparam int DEF_P0          = 50_000_000;
    localparam int DEF_P1          = 25_000_000;
    localparam int DEF_P2          = 12_500_000;
    localparam int DEF_P3          = 6_250_000;
    localparam int DEF_DIV_W       = 26;
    localparam int DEF_GEN_W       = 16;
    localparam int DEF_LOAD_CYCLES = 2;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw push-button level followed by a
// rising-edge detector; a held button yields a single pulse.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/life_pacer.sv
// Generation controller: button edges and speed select become the
// seed-load strobe, the per-generation step enable and extinction halt.
module life_pacer
    import life_pkg::*;
#(
    parameter int P0          = DEF_P0,
    parameter int P1          = DEF_P1,
    parameter int P2          = DEF_P2,
    parameter int P3          = DEF_P3,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int GEN_W       = DEF_GEN_W,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_btn,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic [1:0]       speed,
    input  logic             alive,
    output logic             load,
    output logic             step,
    output logic             running,
    output logic             extinct,
    output logic [GEN_W-1:0] gen_count
);

    localparam int LC_W = $clog2(LOAD_CYCLES) + 1;

    localparam logic [LC_W-1:0]  LC_LAST = LC_W'(LOAD_CYCLES - 1);
    localparam logic [DIV_W-1:0] T0      = DIV_W'(P0 - 1);
    localparam logic [DIV_W-1:0] T1      = DIV_W'(P1 - 1);
    localparam logic [DIV_W-1:0] T2      = DIV_W'(P2 - 1);
    localparam logic [DIV_W-1:0] T3      = DIV_W'(P3 - 1);

    pacer_state_t     state;
    speed_t           spd;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] term;
    logic [LC_W-1:0]  ld_cnt;
    logic [GEN_W-1:0] gen_next;
    logic             at_term;
    logic             load_p;
    logic             run_p;
    logic             step_p;

    btn_edge u_load_edge (
        .clock (clock),
        .reset (reset),
        .raw   (load_btn),
        .pulse (load_p)
    );

    btn_edge u_run_edge (
        .clock (clock),
        .reset (reset),
        .raw   (run_btn),
        .pulse (run_p)
    );

    btn_edge u_step_edge (
        .clock (clock),
        .reset (reset),
        .raw   (step_btn),
        .pulse (step_p)
    );

    assign spd = speed;

    always_comb begin
        term = T0;
        unique case (spd)
            2'd0: term = T0;
            2'd1: term = T1;
            2'd2: term = T2;
            2'd3: term = T3;
        endcase
    end

    // >= rather than == so a shorter period chosen mid-run fires at once
    assign at_term = (div >= term);

    assign gen_next = (gen_count == '1) ? gen_count : gen_count + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            load      <= 1'b0;
            step      <= 1'b0;
            running   <= 1'b0;
            extinct   <= 1'b0;
            gen_count <= '0;
            div       <= '0;
            ld_cnt    <= '0;
        end else begin
            step <= 1'b0;
            if (load_p && state != LOAD) begin
                state     <= LOAD;
                load      <= 1'b1;
                running   <= 1'b0;
                extinct   <= 1'b0;
                gen_count <= '0;
                div       <= '0;
                ld_cnt    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    LOAD: begin
                        if (ld_cnt == LC_LAST) begin
                            load  <= 1'b0;
                            state <= PAUSE;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (run_p) begin
                            state   <= RUN;
                            running <= 1'b1;
                            div     <= '0;
                        end else if (step_p) begin
                            step      <= 1'b1;
                            gen_count <= gen_next;
                        end
                    end
                    RUN: begin
                        if (run_p) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (at_term) begin
                            div <= '0;
                            if (alive) begin
                                step      <= 1'b1;
                                gen_count <= gen_next;
                            end else begin
                                extinct <= 1'b1;
                                state   <= PAUSE;
                                running <= 1'b0;
                            end
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_pacer.sv
// Directed bench for life_pacer with short periods (4/3/2/1 clocks)
// and a 4-bit generation counter.
module tb_life_pacer;

    logic       clock;
    logic       reset;
    logic       load_btn;
    logic       run_btn;
    logic       step_btn;
    logic [1:0] speed;
    logic       alive;
    logic       load;
    logic       step;
    logic       running;
    logic       extinct;
    logic [3:0] gen_count;

    int total;
    int bad;

    life_pacer #(
        .P0          (4),
        .P1          (3),
        .P2          (2),
        .P3          (1),
        .DIV_W       (8),
        .GEN_W       (4),
        .LOAD_CYCLES (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_btn  (load_btn),
        .run_btn   (run_btn),
        .step_btn  (step_btn),
        .speed     (speed),
        .alive     (alive),
        .load      (load),
        .step      (step),
        .running   (running),
        .extinct   (extinct),
        .gen_count (gen_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // press {load,run,step} for one cycle; the reaction is visible on return
    task automatic tap(input logic [2:0] m);
        {load_btn, run_btn, step_btn} = m;
        tick();
        {load_btn, run_btn, step_btn} = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total += 5;
        if (load !== 1'b0) begin
            bad++; $display("FAIL reset_load got=%b want=0", load);
        end
        if (step !== 1'b0) begin
            bad++; $display("FAIL reset_step got=%b want=0", step);
        end
        if (running !== 1'b0) begin
            bad++; $display("FAIL reset_running got=%b want=0", running);
        end
        if (extinct !== 1'b0) begin
            bad++; $display("FAIL reset_extinct got=%b want=0", extinct);
        end
        if (gen_count !== 4'd0) begin
            bad++; $display("FAIL reset_gen got=%0d want=0", gen_count);
        end
    endtask

    task automatic test_idle_ignore();
        tap(3'b010);
        total++;
        if (running !== 1'b0) begin
            bad++; $display("FAIL idle_run got=%b want=0", running);
        end
        tap(3'b001);
        total += 2;
        if (step !== 1'b0) begin
            bad++; $display("FAIL idle_step got=%b want=0", step);
        end
        if (gen_count !== 4'd0) begin
            bad++; $display("FAIL idle_gen got=%0d want=0", gen_count);
        end
    endtask

    task automatic test_load();
        logic exp;
        load_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) load_btn = 1'b0;
            tick();
            exp = (i == 3 || i == 4);
            total++;
            if (load !== exp) begin
                bad++; $display("FAIL load_strobe cyc=%0d got=%b want=%b", i, load, exp);
            end
        end
        total += 2;
        if (gen_count !== 4'd0) begin
            bad++; $display("FAIL load_gen got=%0d want=0", gen_count);
        end
        if (running !== 1'b0) begin
            bad++; $display("FAIL load_running got=%b want=0", running);
        end
    endtask

    task automatic test_run();
        logic exp;
        speed = 2'd0;
        alive = 1'b1;
        tap(3'b010);
        total += 2;
        if (running !== 1'b1) begin
            bad++; $display("FAIL run_enter got=%b want=1", running);
        end
        if (step !== 1'b0) begin
            bad++; $display("FAIL run_enter_step got=%b want=0", step);
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp = (i % 4 == 0);
            total++;
            if (step !== exp) begin
                bad++; $display("FAIL run_step cyc=%0d got=%b want=%b", i, step, exp);
            end
        end
        total++;
        if (gen_count !== 4'd3) begin
            bad++; $display("FAIL run_gen got=%0d want=3", gen_count);
        end
    endtask

    task automatic test_speed_change();
        tick();
        tick();
        speed = 2'd3;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (step !== 1'b1) begin
                bad++; $display("FAIL speed_step cyc=%0d got=%b want=1", i, step);
            end
        end
        total++;
        if (gen_count !== 4'd6) begin
            bad++; $display("FAIL speed_gen got=%0d want=6", gen_count);
        end
    endtask

    task automatic test_extinct();
        logic exp;
        speed = 2'd1;
        alive = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = (i == 3);
            total += 3;
            if (step !== 1'b0) begin
                bad++; $display("FAIL ext_step cyc=%0d got=%b want=0", i, step);
            end
            if (extinct !== exp) begin
                bad++; $display("FAIL ext_flag cyc=%0d got=%b want=%b", i, extinct, exp);
            end
            if (running !== !exp) begin
                bad++; $display("FAIL ext_running cyc=%0d got=%b want=%b", i, running, !exp);
            end
        end
        total++;
        if (gen_count !== 4'd6) begin
            bad++; $display("FAIL ext_gen got=%0d want=6", gen_count);
        end
        tap(3'b001);
        total += 3;
        if (step !== 1'b1) begin
            bad++; $display("FAIL ext_manual_step got=%b want=1", step);
        end
        if (gen_count !== 4'd7) begin
            bad++; $display("FAIL ext_manual_gen got=%0d want=7", gen_count);
        end
        if (extinct !== 1'b1) begin
            bad++; $display("FAIL ext_sticky got=%b want=1", extinct);
        end
        tick();
        total++;
        if (step !== 1'b0) begin
            bad++; $display("FAIL ext_step_width got=%b want=0", step);
        end
    endtask

    task automatic test_saturate_and_priority();
        alive = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tap(3'b001);
            total++;
            if (step !== 1'b1) begin
                bad++; $display("FAIL sat_step n=%0d got=%b want=1", i, step);
            end
        end
        total++;
        if (gen_count !== 4'd15) begin
            bad++; $display("FAIL sat_reach got=%0d want=15", gen_count);
        end
        tap(3'b001);
        total += 2;
        if (step !== 1'b1) begin
            bad++; $display("FAIL sat_last_step got=%b want=1", step);
        end
        if (gen_count !== 4'd15) begin
            bad++; $display("FAIL sat_hold got=%0d want=15", gen_count);
        end
        tap(3'b110);
        total += 4;
        if (load !== 1'b1) begin
            bad++; $display("FAIL prio_load got=%b want=1", load);
        end
        if (running !== 1'b0) begin
            bad++; $display("FAIL prio_running got=%b want=0", running);
        end
        if (gen_count !== 4'd0) begin
            bad++; $display("FAIL prio_gen got=%0d want=0", gen_count);
        end
        if (extinct !== 1'b0) begin
            bad++; $display("FAIL prio_extinct got=%b want=0", extinct);
        end
        tick();
        total++;
        if (load !== 1'b1) begin
            bad++; $display("FAIL prio_load2 got=%b want=1", load);
        end
        tick();
        total++;
        if (load !== 1'b0) begin
            bad++; $display("FAIL prio_load_end got=%b want=0", load);
        end
        speed = 2'd0;
        tap(3'b010);
        total++;
        if (running !== 1'b1) begin
            bad++; $display("FAIL toggle_run got=%b want=1", running);
        end
        tap(3'b010);
        total += 3;
        if (running !== 1'b0) begin
            bad++; $display("FAIL toggle_pause got=%b want=0", running);
        end
        if (step !== 1'b0) begin
            bad++; $display("FAIL toggle_step got=%b want=0", step);
        end
        if (gen_count !== 4'd0) begin
            bad++; $display("FAIL toggle_gen got=%0d want=0", gen_count);
        end
    endtask

    task automatic test_reset_in_load();
        tap(3'b100);
        total++;
        if (load !== 1'b1) begin
            bad++; $display("FAIL rl_load_start got=%b want=1", load);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total += 5;
        if (load !== 1'b0) begin
            bad++; $display("FAIL rl_load got=%b want=0", load);
        end
        if (step !== 1'b0) begin
            bad++; $display("FAIL rl_step got=%b want=0", step);
        end
        if (running !== 1'b0) begin
            bad++; $display("FAIL rl_running got=%b want=0", running);
        end
        if (extinct !== 1'b0) begin
            bad++; $display("FAIL rl_extinct got=%b want=0", extinct);
        end
        if (gen_count !== 4'd0) begin
            bad++; $display("FAIL rl_gen got=%0d want=0", gen_count);
        end
        tick();
        total++;
        if (load !== 1'b0) begin
            bad++; $display("FAIL rl_load_resume got=%b want=0", load);
        end
        tap(3'b010);
        total++;
        if (running !== 1'b0) begin
            bad++; $display("FAIL rl_idle_run got=%b want=0", running);
        end
        tap(3'b001);
        total++;
        if (step !== 1'b0) begin
            bad++; $display("FAIL rl_idle_step got=%b want=0", step);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        load_btn = 1'b0;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        speed    = 2'd0;
        alive    = 1'b1;
        test_reset();
        test_idle_ignore();
        test_load();
        test_run();
        test_speed_change();
        test_extinct();
        test_saturate_and_priority();
        test_reset_in_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
